// File: rtl/dcache_wb_buffer.sv
// Write-back buffer for D-cache dirty victims: a coalescing circular FIFO drained as BUS_STORE requests.
// Optional macro DCACHE_WB_FORWARD_EN enables the load probe (rd_hit/rd_data); otherwise both are tied to 0.
module dcache_wb_buffer #(
    parameter int WB_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          evict_valid,
    input  logic [63:0]                   evict_addr,
    input  logic [63:0]                   evict_data,
    input  logic [63:0]                   rd_addr,
    output logic                          rd_hit,
    output logic [63:0]                   rd_data,
    input  logic                          flush_req,
    output logic                          flush_done,
    input  logic                          mem_grant,
    input  logic [3:0]                    mem2proc_response,
    output logic [1:0]                    proc2mem_command,
    output logic [63:0]                   proc2mem_addr,
    output logic [63:0]                   proc2mem_data,
    output logic                          wb_full,
    output logic                          wb_empty,
    output logic [$clog2(WB_DEPTH+1)-1:0] wb_count,
    output logic                          wb_overflow
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    localparam logic [1:0] BUS_NONE  = 2'h0;
    localparam logic [1:0] BUS_STORE = 2'h2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WB_DEPTH);

    logic             r_vld   [WB_DEPTH];
    logic [60:0]      r_baddr [WB_DEPTH];
    logic [63:0]      r_data  [WB_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_state;
    logic             r_flush;
    logic             r_ovf;

    logic             w_evict_hit;
    logic [PTR_W-1:0] w_evict_idx;
    logic             w_full;
    logic             w_busy_req;
    logic             w_pop;
    logic             w_push_coal;
    logic             w_push_app;
    logic             w_drop;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_state_nxt;
    logic             w_flush_pend;

    // Coalescing guarantees at most one valid entry per block address.
    always_comb begin
        w_evict_hit = 1'b0;
        w_evict_idx = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (r_vld[i] && (r_baddr[i] == evict_addr[63:3])) begin
                w_evict_hit = 1'b1;
                w_evict_idx = PTR_W'(i);
            end
        end
    end

    assign w_full       = (r_count == CNT_FULL);
    assign w_busy_req   = (r_state == S_REQ) && mem_grant && (r_count != '0);
    assign w_pop        = w_busy_req && (mem2proc_response != 4'h0);
    assign w_flush_pend = r_flush || flush_req;

    // A match on the head that is leaving this cycle cannot absorb the push; append instead.
    assign w_push_coal = evict_valid && w_evict_hit && !(w_pop && (w_evict_idx == r_head));
    assign w_push_app  = evict_valid && !w_push_coal && (!w_full || w_pop);
    assign w_drop      = evict_valid && !w_push_coal && w_full && !w_pop;

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_push_app && !w_pop)
            w_cnt_nxt = r_count + CNT_ONE;
        else if (!w_push_app && w_pop)
            w_cnt_nxt = r_count - CNT_ONE;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cnt_nxt != '0)
                    w_state_nxt = S_REQ;
                else if (w_flush_pend)
                    w_state_nxt = S_DONE;
            end
            S_REQ: begin
                if (w_cnt_nxt == '0)
                    w_state_nxt = w_flush_pend ? S_DONE : S_IDLE;
            end
            S_DONE:  w_state_nxt = (w_cnt_nxt != '0) ? S_REQ : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_flush <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < WB_DEPTH; i++)
                r_vld[i] <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_cnt_nxt;
            if (w_drop)
                r_ovf <= 1'b1;
            // A request landing in DONE stays pending so it gets its own completion pulse.
            if (r_state == S_DONE)
                r_flush <= flush_req;
            else if (flush_req)
                r_flush <= 1'b1;
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PTR_ONE;
            end
            if (w_push_coal)
                r_data[w_evict_idx] <= evict_data;
            if (w_push_app) begin
                r_vld[r_tail]   <= 1'b1;
                r_baddr[r_tail] <= evict_addr[63:3];
                r_data[r_tail]  <= evict_data;
                r_tail          <= r_tail + PTR_ONE;
            end
        end
    end

    assign proc2mem_command = w_busy_req ? BUS_STORE : BUS_NONE;
    assign proc2mem_addr    = w_busy_req ? {r_baddr[r_head], 3'b000} : 64'h0;
    assign proc2mem_data    = w_busy_req ? r_data[r_head] : 64'h0;

    assign flush_done  = (r_state == S_DONE);
    assign wb_full     = w_full;
    assign wb_empty    = (r_count == '0);
    assign wb_count    = r_count;
    assign wb_overflow = r_ovf;

`ifdef DCACHE_WB_FORWARD_EN
    logic        w_rd_hit;
    logic [63:0] w_rd_data;
    logic        w_unused;

    always_comb begin
        w_rd_hit  = 1'b0;
        w_rd_data = 64'h0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (r_vld[i] && (r_baddr[i] == rd_addr[63:3])) begin
                w_rd_hit  = 1'b1;
                w_rd_data = w_rd_data | r_data[i];
            end
        end
    end

    assign rd_hit   = w_rd_hit;
    assign rd_data  = w_rd_data;
    assign w_unused = ^{evict_addr[2:0], rd_addr[2:0]};
`else
    logic w_unused;

    assign rd_hit   = 1'b0;
    assign rd_data  = 64'h0;
    assign w_unused = ^{evict_addr[2:0], rd_addr};
`endif

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed self-checking bench for dcache_wb_buffer (WB_DEPTH=4); probe expectations follow DCACHE_WB_FORWARD_EN.
module tb_dcache_wb_buffer;
    localparam logic [1:0] BUS_NONE  = 2'h0;
    localparam logic [1:0] BUS_STORE = 2'h2;
`ifdef DCACHE_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        evict_valid;
    logic [63:0] evict_addr;
    logic [63:0] evict_data;
    logic [63:0] rd_addr;
    logic        rd_hit;
    logic [63:0] rd_data;
    logic        flush_req;
    logic        flush_done;
    logic        mem_grant;
    logic [3:0]  mem2proc_response;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic        wb_full;
    logic        wb_empty;
    logic [2:0]  wb_count;
    logic        wb_overflow;

    int n_assert = 0;
    int n_fail   = 0;

    dcache_wb_buffer #(.WB_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_grant(mem_grant), .mem2proc_response(mem2proc_response),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .wb_full(wb_full), .wb_empty(wb_empty), .wb_count(wb_count),
        .wb_overflow(wb_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow after another unit.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] dv(input logic [63:0] a);
        return 64'hD000_0000_0000_0000 | a;
    endfunction

    task automatic push(input logic [63:0] a, input logic [63:0] d);
        evict_valid = 1'b1;
        evict_addr  = a;
        evict_data  = d;
    endtask

    task automatic chk_store(input string tag, input logic [63:0] a, input logic [63:0] d);
        chk({tag, "_cmd"}, 64'(proc2mem_command), 64'(BUS_STORE));
        chk({tag, "_addr"}, proc2mem_addr, a);
        chk({tag, "_data"}, proc2mem_data, d);
    endtask

    initial begin
        reset = 1'b1; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
        rd_addr = '0; flush_req = 1'b0; mem_grant = 1'b0; mem2proc_response = 4'h0;
        tick(); tick();
        chk("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("rst_addr", proc2mem_addr, 64'h0);
        chk("rst_data", proc2mem_data, 64'h0);
        chk("rst_empty", 64'(wb_empty), 64'h1);
        chk("rst_full", 64'(wb_full), 64'h0);
        chk("rst_count", 64'(wb_count), 64'h0);
        chk("rst_ovf", 64'(wb_overflow), 64'h0);
        chk("rst_fdone", 64'(flush_done), 64'h0);
        chk("rst_hit", 64'(rd_hit), 64'h0);
        chk("rst_rdata", rd_data, 64'h0);
        reset = 1'b0;

        // single evict then drain
        push(64'h1000, 64'hDEADBEEF_00000001);
        mem_grant = 1'b1; mem2proc_response = 4'h3;
        tick();
        evict_valid = 1'b0;
        #1;
        chk_store("t1_store", 64'h1000, 64'hDEADBEEF_00000001);
        tick();
        chk("t1_empty", 64'(wb_empty), 64'h1);
        chk("t1_idle_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        mem_grant = 1'b0; mem2proc_response = 4'h0;

        // fill, overflow, then in-order drain
        for (int i = 0; i < 5; i++) begin
            push(64'h100 + 64'(i * 8), dv(64'h100 + 64'(i * 8)));
            tick();
            if (i == 3) begin
                chk("t2_full4", 64'(wb_full), 64'h1);
                chk("t2_cnt4", 64'(wb_count), 64'h4);
                chk("t2_ovf4", 64'(wb_overflow), 64'h0);
            end
        end
        evict_valid = 1'b0;
        #1;
        chk("t2_ovf", 64'(wb_overflow), 64'h1);
        chk("t2_cnt5", 64'(wb_count), 64'h4);
        chk("t2_nogrant_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        rd_addr = 64'h11C;
        #1;
        chk("t2_probe_hit", 64'(rd_hit), FWD ? 64'h1 : 64'h0);
        chk("t2_probe_data", rd_data, FWD ? dv(64'h118) : 64'h0);
        rd_addr = 64'h120;
        #1;
        chk("t2_drop_hit", 64'(rd_hit), 64'h0);
        chk("t2_drop_data", rd_data, 64'h0);
        mem_grant = 1'b1; mem2proc_response = 4'h1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_store("t2_drain", 64'h100 + 64'(i * 8), dv(64'h100 + 64'(i * 8)));
            tick();
        end
        chk("t2_empty", 64'(wb_empty), 64'h1);
        chk("t2_ovf_sticky", 64'(wb_overflow), 64'h1);
        mem_grant = 1'b0; mem2proc_response = 4'h0;

        // coalesce
        push(64'h2008, 64'hAAAA);
        tick();
        push(64'h2008, 64'hBBBB);
        tick();
        evict_valid = 1'b0;
        rd_addr = 64'h200F;
        #1;
        chk("t3_cnt", 64'(wb_count), 64'h1);
        chk("t3_hit", 64'(rd_hit), FWD ? 64'h1 : 64'h0);
        chk("t3_rdata", rd_data, FWD ? 64'hBBBB : 64'h0);
        mem_grant = 1'b1; mem2proc_response = 4'h1;
        #1;
        chk_store("t3_store", 64'h2008, 64'hBBBB);
        tick();
        chk("t3_one_store", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("t3_empty", 64'(wb_empty), 64'h1);
        mem_grant = 1'b0; mem2proc_response = 4'h0;

        // refused requests are retried with the same head
        push(64'h3000, dv(64'h3000));
        tick();
        evict_valid = 1'b0;
        mem_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_store("t4_retry", 64'h3000, dv(64'h3000));
            chk("t4_retry_cnt", 64'(wb_count), 64'h1);
            tick();
        end
        mem2proc_response = 4'h1;
        #1;
        chk_store("t4_accept", 64'h3000, dv(64'h3000));
        tick();
        chk("t4_empty", 64'(wb_empty), 64'h1);
        mem_grant = 1'b0; mem2proc_response = 4'h0;

        // flush during traffic, with a push after the flush request
        push(64'h4000, dv(64'h4000));
        tick();
        push(64'h4008, dv(64'h4008));
        tick();
        evict_valid = 1'b0;
        mem_grant = 1'b1; mem2proc_response = 4'h1; flush_req = 1'b1;
        #1;
        chk_store("t5_s0", 64'h4000, dv(64'h4000));
        tick();
        flush_req = 1'b0;
        push(64'h4010, dv(64'h4010));
        #1;
        chk_store("t5_s1", 64'h4008, dv(64'h4008));
        chk("t5_fd1", 64'(flush_done), 64'h0);
        tick();
        evict_valid = 1'b0;
        #1;
        chk_store("t5_s2", 64'h4010, dv(64'h4010));
        chk("t5_fd2", 64'(flush_done), 64'h0);
        tick();
        chk("t5_fd_pulse", 64'(flush_done), 64'h1);
        chk("t5_done_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("t5_empty", 64'(wb_empty), 64'h1);
        tick();
        chk("t5_fd_once", 64'(flush_done), 64'h0);
        mem_grant = 1'b0; mem2proc_response = 4'h0;

        // flush while already empty completes on the next edge
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        #1;
        chk("t5e_fd", 64'(flush_done), 64'h1);
        tick();
        chk("t5e_fd_off", 64'(flush_done), 64'h0);

        // reset mid-request
        for (int i = 0; i < 3; i++) begin
            push(64'h5000 + 64'(i * 8), dv(64'h5000 + 64'(i * 8)));
            tick();
        end
        evict_valid = 1'b0;
        mem_grant = 1'b1;
        #1;
        chk_store("t6_pre", 64'h5000, dv(64'h5000));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t6_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("t6_empty", 64'(wb_empty), 64'h1);
        chk("t6_ovf_clr", 64'(wb_overflow), 64'h0);
        for (int i = 0; i < 3; i++) begin
            rd_addr = 64'h5000 + 64'(i * 8);
            #1;
            chk("t6_nohit", 64'(rd_hit), 64'h0);
        end
        mem_grant = 1'b0;

        // push and pop in the same cycle while full
        for (int i = 0; i < 4; i++) begin
            push(64'h6000 + 64'(i * 8), dv(64'h6000 + 64'(i * 8)));
            tick();
        end
        push(64'h6020, dv(64'h6020));
        mem_grant = 1'b1; mem2proc_response = 4'h1;
        #1;
        chk_store("t7_head", 64'h6000, dv(64'h6000));
        tick();
        evict_valid = 1'b0;
        #1;
        chk("t7_cnt", 64'(wb_count), 64'h4);
        chk("t7_full", 64'(wb_full), 64'h1);
        chk("t7_noovf", 64'(wb_overflow), 64'h0);
        for (int i = 1; i < 5; i++) begin
            #1;
            chk_store("t7_drain", 64'h6000 + 64'(i * 8), dv(64'h6000 + 64'(i * 8)));
            tick();
        end
        chk("t7_empty", 64'(wb_empty), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_wb_buffer.md
# dcache_wb_buffer

Write-back buffer on the eviction side of the 4-way D-cache. It accepts dirty victim lines pushed by the cache on a miss refill and queues them in FIFO order. It drains them to memory as `BUS_STORE` requests whenever the memory arbiter grants the bus. Loads probe it so that data evicted but not yet written back is never lost or read stale from memory.

## Interface
- `WB_DEPTH`, 4: number of entries; a power of two, at least 2.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `evict_valid` in 1: push request; asserted only for victims that are both valid and dirty.
- `evict_addr` in 64: victim address in `SASS_ADDR` layout (tag, set_index, ignore=3'b000).
- `evict_data` in 64: victim line data.
- `rd_addr` in 64: load probe address; `ignore` bits are not compared.
- `rd_hit` out 1: probe matches a buffered entry.
- `rd_data` out 64: data of the matching entry.
- `flush_req` in 1: one-cycle pulse requesting a full drain (end of program / halt).
- `flush_done` out 1: one-cycle pulse when the flush completes.
- `mem_grant` in 1: the arbiter gives this block the memory bus this cycle.
- `mem2proc_response` in 4: nonzero means the command presented this cycle was accepted.
- `proc2mem_command` out 2: `BUS_NONE` or `BUS_STORE`.
- `proc2mem_addr` out 64: head address with bits [2:0] forced to 0.
- `proc2mem_data` out 64: head data.
- `wb_full` out 1: count == `WB_DEPTH`.
- `wb_empty` out 1: count == 0.
- `wb_count` out $clog2(`WB_DEPTH`+1): number of occupied entries.
- `wb_overflow` out 1: sticky; set when a push is dropped.

## Operation
- Storage is a circular FIFO with head and tail pointers. Each entry holds a valid bit, a 61-bit block address and 64-bit data.
- Push (`evict_valid`):
  - If an entry has a matching block address and is not being popped this cycle, coalesce by overwriting its data in place. Count is unchanged.
  - Otherwise append at the tail and increment tail with wrap-around.
  - If the buffer is full and no pop occurs this cycle, drop the push and set `wb_overflow`.
  - A push and a pop in the same cycle while full is legal: the new entry takes the tail slot and count is unchanged.
- Because of coalescing, at most one entry ever matches a given block address.
- Probe: `rd_hit`/`rd_data` compare `rd_addr` against all valid entries combinationally. With no match, `rd_data` = 0.
- State machine:
  - IDLE: buffer is empty. Go to REQ when an entry is written.
  - REQ: drive `BUS_STORE` with the head entry only while `mem_grant`=1; otherwise drive `BUS_NONE`. If the response is nonzero, pop the head. Return to IDLE when the pop empties the buffer and no flush is pending. Go to DONE when the pop empties the buffer and a flush is pending.
  - DONE: pulse `flush_done` for one cycle, then go to IDLE.
- Flush:
  - A flush pending flag is set on `flush_req` and cleared in DONE.
  - `flush_req` while already empty goes straight to DONE on the next edge.
  - Pushes during a flush are still accepted and are drained before DONE.
- Reset overrides everything, including mid-flush and mid-request. All entries become invalid, pointers go to 0, state goes to IDLE, and the flush and overflow flags clear.

## Timing
- Reset values of outputs: `proc2mem_command`=`BUS_NONE`, `proc2mem_addr`=0, `proc2mem_data`=0, `rd_hit`=0, `rd_data`=0, `wb_empty`=1, `wb_full`=0, `wb_count`=0, `flush_done`=0, `wb_overflow`=0.
- A push at edge N is visible to the probe and to count in cycle N+1. There is no same-cycle bypass to `rd_hit`.
- The earliest store for an entry pushed at edge N is in cycle N+1, given `mem_grant`.
- `proc2mem_*` are combinational from state, head and `mem_grant`. `mem2proc_response` is sampled in the same cycle.
- A refused request (response 0) leaves the head unchanged and is retried on the next granted cycle.
- Throughput is one store per cycle under continuous grant and accept.
- `flush_done` asserts in the cycle after the last pop.
- `proc2mem_addr`/`proc2mem_data` are 0 whenever the command is `BUS_NONE`.

## Configuration
- Macro `DCACHE_WB_FORWARD_EN`.
- Defined: the probe compare logic and `rd_hit`/`rd_data` behave as described above.
- Undefined: the compare logic is removed and `rd_hit`/`rd_data` are tied to 0. The cache controller must then stall a load miss until `wb_empty`=1.

## Test plan
- Single evict then drain: push addr 0x1000 with data 0xDEADBEEF_00000001, `mem_grant`=1 and response=3. Required: in cycle N+1 the command is `BUS_STORE` with addr 0x1000 and that data, and at edge N+2 `wb_empty`=1.
- Fill and overflow (`WB_DEPTH`=4), grant held 0: push 5 distinct addresses. Required: `wb_full`=1 after the 4th push, the 5th push sets `wb_overflow`=1 and `wb_count` stays 4. Then grant the bus and check the stores come out in push order.
- Coalesce: push 0x2008 with data 0xAAAA, then push 0x2008 with data 0xBBBB. Required: `wb_count`=1, a probe of 0x200F gives `rd_hit`=1 with data 0xBBBB, and exactly one store carries 0xBBBB.
- Retry: hold the response at 0 for 3 granted cycles, then set it to 1. Required: the same head is presented 4 times and popped once.
- Flush during traffic: 2 entries queued, pulse `flush_req`, and push a third entry the next cycle. Required: 3 stores, then `flush_done` pulses once in the cycle after the last pop.
- Reset mid-request while in REQ with 3 entries queued: assert `reset` for 1 cycle. Required: the next cycle shows `BUS_NONE`, `wb_empty`=1 and `rd_hit`=0 for all three addresses.
